// File: rtl/proc_subtraction_mc_pkg.sv
// proc_sub_pkg: shared constants and sizing helpers
// for the frame-difference accumulator.
package proc_sub_pkg;

   localparam int MODE_ABS = 0;
   localparam int MODE_POS = 1;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int sum_w_dflt(
      input int lanes,
      input int lane_w,
      input int addr_w
   );
      return lane_w + clog2(lanes) + addr_w;
   endfunction

endpackage

// File: rtl/proc_subtraction_mc_if.sv
// proc_subtraction_mc_if: write port, frame marker
// and published frame results.
interface proc_subtraction_mc_if
   import proc_sub_pkg::*;
#(
   parameter int LANES  = 5,
   parameter int LANE_W = 8,
   parameter int ADDR_W = 15,
   parameter int SUM_W  = sum_w_dflt(LANES, LANE_W, ADDR_W)
);
   logic [ADDR_W-1:0]       i_rec_addr;
   logic                    i_rec_ce;
   logic                    i_rec_we;
   logic [LANES*LANE_W-1:0] i_rec_d;
   logic                    refresh;
   logic [SUM_W-1:0]        i_thresh;
   logic [SUM_W-1:0]        sum_traction;
   logic                    o_sum_valid;
   logic                    o_ovf;
   logic                    o_alarm;
   logic [15:0]             o_frame_cnt;

   modport master (
      output i_rec_addr, i_rec_ce, i_rec_we, i_rec_d,
      output refresh, i_thresh,
      input  sum_traction, o_sum_valid, o_ovf,
      input  o_alarm, o_frame_cnt
   );

   modport slave (
      input  i_rec_addr, i_rec_ce, i_rec_we, i_rec_d,
      input  refresh, i_thresh,
      output sum_traction, o_sum_valid, o_ovf,
      output o_alarm, o_frame_cnt
   );
endinterface

// File: rtl/proc_subtraction_mc_dpram.sv
// sub_dpram: simple dual-port RAM, registered read,
// read-first on a same-address write.
module sub_dpram #(
   parameter int W  = 40,
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   localparam int DEPTH = 1 << AW;

   logic [W-1:0] mem [DEPTH];

`ifdef SIM
   initial begin
      for (int i = 0; i < DEPTH; i++)
         mem[i] = '0;
   end
`endif

   always_ff @(posedge clk) begin
      if (re)
         rdata <= mem[raddr];
      if (we)
         mem[waddr] <= wdata;
   end

endmodule

// File: rtl/proc_subtraction_mc.sv
// proc_subtraction_mc: multi-lane frame-difference accumulator.
// RAM compare, lane diff, adder tree, saturating frame sum.
module proc_subtraction_mc
   import proc_sub_pkg::*;
#(
   parameter int LANES  = 5,
   parameter int LANE_W = 8,
   parameter int ADDR_W = 15,
   parameter int MODE   = MODE_ABS,
   parameter int SUM_W  = sum_w_dflt(LANES, LANE_W, ADDR_W)
) (
   input logic clk_200M,
   input logic rst_200M,
   proc_subtraction_mc_if.slave bus
);
   localparam int DW   = LANES * LANE_W;
   localparam int LS_W = LANE_W + clog2(LANES);
   localparam int EW   = ((SUM_W > LS_W) ? SUM_W : LS_W) + 1;
   localparam logic [EW-1:0] MAXV =
      {{(EW-SUM_W){1'b0}}, {SUM_W{1'b1}}};

   logic              wr0;
   logic              v1, v2, v3;
   logic              r1, r2, r3;
   logic              primed, sat;
   logic [DW-1:0]     old1, new1;
   logic [LANE_W-1:0] diff_c [LANES];
   logic [LANE_W-1:0] diff2  [LANES];
   logic [LS_W-1:0]   lsum_c, lsum3, add_c;
   logic [SUM_W-1:0]  acc, sum_q;
   logic [EW-1:0]     base_c, tot_c;
   logic              hit_c;
   logic              valid_q, ovf_q, alarm_q;
   logic [15:0]       fcnt_q;

   assign wr0 = bus.i_rec_ce & bus.i_rec_we;

   sub_dpram #(.W(DW), .AW(ADDR_W)) u_ram (
      .clk   (clk_200M),
      .we    (wr0),
      .waddr (bus.i_rec_addr),
      .wdata (bus.i_rec_d),
      .re    (wr0),
      .raddr (bus.i_rec_addr),
      .rdata (old1)
   );

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [LANE_W-1:0] a, b;
      assign a = new1[k*LANE_W +: LANE_W];
      assign b = old1[k*LANE_W +: LANE_W];
      if (MODE == MODE_POS) begin : g_pos
         assign diff_c[k] = (a > b) ? a - b : '0;
      end else begin : g_abs
         assign diff_c[k] = (a >= b) ? a - b : b - a;
      end
   end

   always_comb begin
      lsum_c = '0;
      for (int k = 0; k < LANES; k++)
         lsum_c = lsum_c + LS_W'(diff2[k]);
   end

   // First frame after reset has no trustworthy reference words.
   assign add_c  = (v3 && primed) ? lsum3 : '0;
   assign base_c = r3 ? '0 : EW'(acc);
   assign tot_c  = base_c + EW'(add_c);
   assign hit_c  = tot_c > MAXV;

   always_ff @(posedge clk_200M) begin
      new1  <= bus.i_rec_d;
      diff2 <= diff_c;
      lsum3 <= lsum_c;
   end

   always_ff @(posedge clk_200M or posedge rst_200M) begin
      if (rst_200M) begin
         {v1, v2, v3} <= '0;
         {r1, r2, r3} <= '0;
         primed  <= 1'b0;
         sat     <= 1'b0;
         acc     <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         alarm_q <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         v1 <= wr0;
         r1 <= bus.refresh;
         v2 <= v1;
         r2 <= r1;
         v3 <= v2;
         r3 <= r2;
         acc <= hit_c ? MAXV[SUM_W-1:0] : tot_c[SUM_W-1:0];
         sat <= (sat & ~r3) | hit_c;
         valid_q <= r3;
         if (r3) begin
            sum_q   <= acc;
            ovf_q   <= sat;
            alarm_q <= acc > bus.i_thresh;
            fcnt_q  <= fcnt_q + 16'd1;
            primed  <= 1'b1;
         end
      end
   end

   assign bus.sum_traction = sum_q;
   assign bus.o_sum_valid  = valid_q;
   assign bus.o_ovf        = ovf_q;
   assign bus.o_alarm      = alarm_q;
   assign bus.o_frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_proc_subtraction_mc.sv
// tb_proc_subtraction_mc: three configurations driven with directed
// and random frames, checked by a scoreboard against a frame model.
module tb_proc_subtraction_mc;
   import proc_sub_pkg::*;

   typedef struct packed {
      logic [63:0] sum;
      logic        ovf;
      logic        alarm;
      logic [15:0] fcnt;
      logic [63:0] cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   logic [63:0] addr [3];
   logic [63:0] dat  [3];
   logic [63:0] thr  [3];
   logic        ce   [3];
   logic        we   [3];
   logic        rf   [3];

   logic [63:0] o_sum [3];
   logic        o_v   [3];
   logic        o_o   [3];
   logic        o_a   [3];
   logic [15:0] o_f   [3];

   longint unsigned mem [int];
   longint unsigned fsum [3];
   bit              sat [3];
   bit              primed [3];
   int              fcnt [3];
   exp_t            q [3][$];
   exp_t            e;

   proc_subtraction_mc_if #(5, 8, 15, 26) ifa ();
   proc_subtraction_mc_if #(2, 8, 2, 10)  ifb ();
   proc_subtraction_mc_if #(3, 4, 3, 9)   ifc ();

   proc_subtraction_mc #(.LANES(5), .LANE_W(8), .ADDR_W(15),
      .MODE(MODE_ABS), .SUM_W(26))
      dut_a (.clk_200M(clk), .rst_200M(rst), .bus(ifa));
   proc_subtraction_mc #(.LANES(2), .LANE_W(8), .ADDR_W(2),
      .MODE(MODE_ABS), .SUM_W(10))
      dut_b (.clk_200M(clk), .rst_200M(rst), .bus(ifb));
   proc_subtraction_mc #(.LANES(3), .LANE_W(4), .ADDR_W(3),
      .MODE(MODE_POS), .SUM_W(9))
      dut_c (.clk_200M(clk), .rst_200M(rst), .bus(ifc));

   assign ifa.i_rec_addr = addr[0][14:0];
   assign ifa.i_rec_ce   = ce[0];
   assign ifa.i_rec_we   = we[0];
   assign ifa.i_rec_d    = dat[0][39:0];
   assign ifa.refresh    = rf[0];
   assign ifa.i_thresh   = thr[0][25:0];
   assign ifb.i_rec_addr = addr[1][1:0];
   assign ifb.i_rec_ce   = ce[1];
   assign ifb.i_rec_we   = we[1];
   assign ifb.i_rec_d    = dat[1][15:0];
   assign ifb.refresh    = rf[1];
   assign ifb.i_thresh   = thr[1][9:0];
   assign ifc.i_rec_addr = addr[2][2:0];
   assign ifc.i_rec_ce   = ce[2];
   assign ifc.i_rec_we   = we[2];
   assign ifc.i_rec_d    = dat[2][11:0];
   assign ifc.refresh    = rf[2];
   assign ifc.i_thresh   = thr[2][8:0];

   assign o_sum[0] = 64'(ifa.sum_traction);
   assign o_sum[1] = 64'(ifb.sum_traction);
   assign o_sum[2] = 64'(ifc.sum_traction);
   assign o_v[0] = ifa.o_sum_valid;
   assign o_v[1] = ifb.o_sum_valid;
   assign o_v[2] = ifc.o_sum_valid;
   assign o_o[0] = ifa.o_ovf;
   assign o_o[1] = ifb.o_ovf;
   assign o_o[2] = ifc.o_ovf;
   assign o_a[0] = ifa.o_alarm;
   assign o_a[1] = ifb.o_alarm;
   assign o_a[2] = ifc.o_alarm;
   assign o_f[0] = ifa.o_frame_cnt;
   assign o_f[1] = ifb.o_frame_cnt;
   assign o_f[2] = ifc.o_frame_cnt;

   function automatic int lanes(int u);
      return (u == 0) ? 5 : (u == 1) ? 2 : 3;
   endfunction
   function automatic int lw(int u);
      return (u == 2) ? 4 : 8;
   endfunction
   function automatic int sumw(int u);
      return (u == 0) ? 26 : (u == 1) ? 10 : 9;
   endfunction
   function automatic int mode(int u);
      return (u == 2) ? 1 : 0;
   endfunction

   function automatic longint unsigned dmask(int u);
      return (64'd1 << (lanes(u) * lw(u))) - 64'd1;
   endfunction

   function automatic longint unsigned fill(int u, int b);
      longint unsigned s = 0;
      longint unsigned m = (64'd1 << lw(u)) - 64'd1;
      for (int k = 0; k < lanes(u); k++)
         s |= (longint'(b) & m) << (k * lw(u));
      return s;
   endfunction

   // Sum over lanes of the per-lane difference rule.
   function automatic longint unsigned lsum(int u,
         longint unsigned nw, longint unsigned od);
      longint unsigned s = 0;
      longint unsigned m = (64'd1 << lw(u)) - 64'd1;
      longint unsigned a, b;
      for (int k = 0; k < lanes(u); k++) begin
         a = (nw >> (k * lw(u))) & m;
         b = (od >> (k * lw(u))) & m;
         if (a > b) s += a - b;
         else if (mode(u) == 0) s += b - a;
      end
      return s;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_drive();
      for (int i = 0; i < 3; i++) begin
         ce[i] = 1'b0;
         we[i] = 1'b0;
         rf[i] = 1'b0;
      end
   endtask

   task automatic step(int u, bit c, bit w, int a,
         longint unsigned d, bit r);
      bit p;
      int key;
      longint unsigned mx, old;
      @(negedge clk);
      clear_drive();
      ce[u] = c;
      we[u] = w;
      addr[u] = 64'(a);
      dat[u] = d;
      rf[u] = r;
      p = primed[u];
      mx = (64'd1 << sumw(u)) - 64'd1;
      if (r) begin
         q[u].push_back('{fsum[u], sat[u], fsum[u] > thr[u],
            16'(fcnt[u] + 1), cyc + 4});
         fcnt[u]++;
         fsum[u] = 0;
         sat[u] = 1'b0;
         primed[u] = 1'b1;
      end
      if (c && w) begin
         key = u * 65536 + a;
         old = mem.exists(key) ? mem[key] : 0;
         if (p) begin
            fsum[u] += lsum(u, d, old);
            if (fsum[u] > mx) begin
               fsum[u] = mx;
               sat[u] = 1'b1;
            end
         end
         mem[key] = d;
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++)
         step(0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic frame(int u, int n, int b);
      for (int a = 0; a < n; a++)
         step(u, 1'b1, 1'b1, a, fill(u, b), 1'b0);
      step(u, 1'b0, 1'b0, 0, 0, 1'b1);
      idle(5);
   endtask

   task automatic rand_run(int u, int n, int na);
      for (int i = 0; i < n; i++)
         step(u, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, na - 1)),
            {$urandom, $urandom} & dmask(u),
            $urandom_range(0, 15) == 0);
      step(u, 1'b0, 1'b0, 0, 0, 1'b1);
      idle(5);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_drive();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("rst_sum u%0d", u), o_sum[u], 0);
         chk($sformatf("rst_valid u%0d", u), 64'(o_v[u]), 0);
         chk($sformatf("rst_ovf u%0d", u), 64'(o_o[u]), 0);
         chk($sformatf("rst_alarm u%0d", u), 64'(o_a[u]), 0);
         chk($sformatf("rst_fcnt u%0d", u), 64'(o_f[u]), 0);
         fsum[u] = 0;
         sat[u] = 1'b0;
         primed[u] = 1'b0;
         fcnt[u] = 0;
         q[u].delete();
      end
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int u = 0; u < 3; u++) begin
            if (o_v[u] === 1'b1) begin
               if (q[u].size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL spurious_valid u%0d: got 1 expected 0", u);
               end else begin
                  e = q[u].pop_front();
                  chk($sformatf("sum u%0d", u), o_sum[u], e.sum);
                  chk($sformatf("ovf u%0d", u), 64'(o_o[u]), 64'(e.ovf));
                  chk($sformatf("alarm u%0d", u), 64'(o_a[u]), 64'(e.alarm));
                  chk($sformatf("fcnt u%0d", u), 64'(o_f[u]), 64'(e.fcnt));
                  chk($sformatf("valid_cycle u%0d", u), cyc, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         addr[i] = 0;
         dat[i] = 0;
         thr[i] = 0;
      end
      clear_drive();
      repeat (3) @(negedge clk);
      do_reset();

      // Default configuration: priming, full swing, return swing.
      thr[0] = 64'd1000;
      frame(0, 18001, 8'h00);
      frame(0, 18001, 8'hFF);
      frame(0, 18001, 8'h00);

      // Same-address hazard against read-first RAM.
      step(0, 1'b1, 1'b1, 7, fill(0, 10), 1'b0);
      step(0, 1'b1, 1'b1, 7, fill(0, 30), 1'b0);
      step(0, 1'b1, 1'b1, 7, fill(0, 25), 1'b0);
      step(0, 1'b0, 1'b0, 0, 0, 1'b1);
      idle(5);

      // Write coincident with refresh, then back-to-back refreshes.
      step(0, 1'b1, 1'b1, 1, fill(0, 1), 1'b1);
      idle(3);
      step(0, 1'b0, 1'b0, 0, 0, 1'b1);
      step(0, 1'b0, 1'b0, 0, 0, 1'b1);
      idle(5);

      thr[0] = 64'd3000;
      rand_run(0, 300, 32);

      // Small config: saturation and alarm.
      thr[1] = 64'd500;
      frame(1, 4, 8'h00);
      frame(1, 4, 8'hFF);
      frame(1, 4, 8'h00);
      frame(1, 4, 8'hFF);
      rand_run(1, 100, 4);

      // Positive-only mode.
      thr[2] = 64'd100;
      frame(2, 8, 0);
      frame(2, 8, 15);
      frame(2, 8, 0);
      rand_run(2, 200, 8);

      // Reset in the middle of a frame.
      for (int i = 0; i < 5; i++)
         step(0, 1'b1, 1'b1, int'($urandom_range(0, 31)),
            {$urandom, $urandom} & dmask(0), 1'b0);
      do_reset();
      rand_run(0, 40, 32);
      rand_run(0, 60, 32);

      idle(8);
      for (int u = 0; u < 3; u++)
         chk($sformatf("drain u%0d", u), 64'(q[u].size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
         n_chk, n_fail);
      $finish;
   end

endmodule
